// File: rtl/shift_rows_stage.sv
`default_nettype none
// ============================================================================
//  Module   : shift_rows_stage
//  Purpose  : Registered Rijndael ShiftRows / InvShiftRows / bypass stage with
//             a 2-entry valid/ready output buffer (Nb = 4, 6 or 8).
//  Revision : 1.0  initial release
// ============================================================================
module shift_rows_stage #(
   parameter int NB = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [32*NB-1:0]  in_state,
   input  logic [1:0]        in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [32*NB-1:0]  out_state,
   output logic [1:0]        out_mode,
   output logic              out_err
);

   localparam int W = 32 * NB;

   localparam logic [1:0] MODE_FWD = 2'b00;
   localparam logic [1:0] MODE_INV = 2'b01;
   localparam logic [1:0] MODE_RSV = 2'b11;

   generate
      if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_nb_illegal
         $error("shift_rows_stage: NB must be 4, 6 or 8");
      end
   endgenerate

   // Rijndael row offsets; only the 256-bit block widens rows 2 and 3.
   function automatic int row_off(input int r);
      int o;
      case (r)
         1:       o = 1;
         2:       o = (NB == 8) ? 3 : 2;
         3:       o = (NB == 8) ? 4 : 3;
         default: o = 0;
      endcase
      return o;
   endfunction

   function automatic logic [W-1:0] shift_rows(input logic [W-1:0] s, input logic inv);
      logic [W-1:0] res;
      int           src_c;
      res = '0;
      for (int c = 0; c < NB; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (inv) src_c = (c + NB - row_off(r)) % NB;
            else     src_c = (c + row_off(r)) % NB;
            res[W-1-8*(4*c+r) -: 8] = s[W-1-8*(4*src_c+r) -: 8];
         end
      end
      return res;
   endfunction

   logic [W-1:0] xf_state;
   logic         xf_err;

   always_comb begin
      xf_state = in_state;
      xf_err   = (in_mode == MODE_RSV);
      if (in_mode == MODE_FWD)      xf_state = shift_rows(in_state, 1'b0);
      else if (in_mode == MODE_INV) xf_state = shift_rows(in_state, 1'b1);
   end

   logic [W-1:0] st_q [2];
   logic [W-1:0] st_d [2];
   logic [1:0]   md_q [2];
   logic [1:0]   md_d [2];
   logic         er_q [2];
   logic         er_d [2];
   logic [1:0]   count_q, count_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic         in_ready_q, in_ready_d;
   logic         push, pop;

   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid & in_ready_q;
   assign pop       = out_valid & out_ready;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         st_d[i] = st_q[i];
         md_d[i] = md_q[i];
         er_d[i] = er_q[i];
         if (push && (wr_ptr_q == i[0])) begin
            st_d[i] = xf_state;
            md_d[i] = in_mode;
            er_d[i] = xf_err;
         end
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      wr_ptr_d   = wr_ptr_q ^ push;
      rd_ptr_d   = rd_ptr_q ^ pop;
      // Registered ready keeps out_ready off the input-side timing path.
      in_ready_d = (count_d != 2'd2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            st_q[i] <= '0;
            md_q[i] <= 2'b00;
            er_q[i] <= 1'b0;
         end
         count_q    <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            st_q[i] <= st_d[i];
            md_q[i] <= md_d[i];
            er_q[i] <= er_d[i];
         end
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_state = st_q[rd_ptr_q];
   assign out_mode  = md_q[rd_ptr_q];
   assign out_err   = er_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_shift_rows_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_rows_stage
//  Purpose  : Directed self-checking bench for shift_rows_stage (NB = 4 and 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_rows_stage;

   logic clk;
   logic rst;

   logic         in4_valid, in4_ready, out4_valid, out4_ready, out4_err;
   logic [127:0] in4_state, out4_state;
   logic [1:0]   in4_mode, out4_mode;

   logic         in8_valid, in8_ready, out8_valid, out8_ready, out8_err;
   logic [255:0] in8_state, out8_state;
   logic [1:0]   in8_mode, out8_mode;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [127:0] FIPS_IN  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
   localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
   localparam logic [255:0] SEQ8     =
      256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
   localparam logic [255:0] SEQ8_FWD =
      256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;

   shift_rows_stage #(.NB(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in4_valid), .in_ready(in4_ready), .in_state(in4_state), .in_mode(in4_mode),
      .out_valid(out4_valid), .out_ready(out4_ready), .out_state(out4_state),
      .out_mode(out4_mode), .out_err(out4_err)
   );

   shift_rows_stage #(.NB(8)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in8_valid), .in_ready(in8_ready), .in_state(in8_state), .in_mode(in8_mode),
      .out_valid(out8_valid), .out_ready(out8_ready), .out_state(out8_state),
      .out_mode(out8_mode), .out_err(out8_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Byte-permutation tables for the 128-bit block (byte index 4c+r).
   function automatic logic [127:0] ref4(input logic [127:0] s, input logic [1:0] m);
      int p_fwd [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
      int p_inv [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
      logic [127:0] r;
      int src;
      r = s;
      if (m == 2'b00 || m == 2'b01) begin
         for (int k = 0; k < 16; k++) begin
            src = (m == 2'b00) ? p_fwd[k] : p_inv[k];
            r[127-8*k -: 8] = s[127-8*src -: 8];
         end
      end
      return r;
   endfunction

   task automatic xfer4(input string tag, input logic [127:0] st, input logic [1:0] md,
                        input logic [127:0] exp_st);
      in4_valid  = 1'b1;
      in4_state  = st;
      in4_mode   = md;
      out4_ready = 1'b1;
      tick();
      in4_valid = 1'b0;
      chk({tag, ".valid"}, out4_valid, 1);
      chk({tag, ".state"}, out4_state, exp_st);
      chk({tag, ".mode"}, out4_mode, md);
      chk({tag, ".err"}, out4_err, (md == 2'b11));
      tick();
      chk({tag, ".drained"}, out4_valid, 0);
   endtask

   initial begin
      logic [127:0] st;
      logic [1:0]   md;

      rst = 1'b1;
      in4_valid = 1'b0; in4_state = '0; in4_mode = 2'b00; out4_ready = 1'b0;
      in8_valid = 1'b0; in8_state = '0; in8_mode = 2'b00; out8_ready = 1'b0;
      tick();
      tick();
      chk("rst.in_ready", in4_ready, 0);
      chk("rst.out_valid", out4_valid, 0);
      chk("rst.out_state", out4_state, 0);
      chk("rst.out_mode", out4_mode, 0);
      chk("rst.out_err", out4_err, 0);
      chk("rst.nb8_in_ready", in8_ready, 0);

      rst = 1'b0;
      tick();
      chk("release.in_ready", in4_ready, 1);
      chk("release.nb8_in_ready", in8_ready, 1);

      xfer4("fips_fwd", FIPS_IN, 2'b00, FIPS_OUT);
      xfer4("fips_inv", FIPS_OUT, 2'b01, FIPS_IN);
      xfer4("bypass", FIPS_IN, 2'b10, FIPS_IN);
      xfer4("reserved", FIPS_OUT, 2'b11, FIPS_OUT);

      // NB = 8: forward then inverse of the result.
      in8_valid = 1'b1; in8_state = SEQ8; in8_mode = 2'b00; out8_ready = 1'b1;
      tick();
      in8_valid = 1'b0;
      chk("nb8_fwd.valid", out8_valid, 1);
      chk("nb8_fwd.word0", out8_state[255:224], 32'h00050e13);
      chk("nb8_fwd.state", out8_state, SEQ8_FWD);
      chk("nb8_fwd.err", out8_err, 0);
      in8_valid = 1'b1; in8_state = out8_state; in8_mode = 2'b01;
      tick();
      in8_valid = 1'b0;
      chk("nb8_inv.state", out8_state, SEQ8);
      chk("nb8_inv.mode", out8_mode, 2'b01);
      tick();
      chk("nb8.drained", out8_valid, 0);

      // Backpressure: A, B fill the buffer, C must wait.
      out4_ready = 1'b0;
      in4_valid = 1'b1; in4_state = FIPS_IN; in4_mode = 2'b00;
      tick();
      in4_state = FIPS_OUT; in4_mode = 2'b01;
      tick();
      in4_state = 128'h0123456789abcdef_fedcba9876543210; in4_mode = 2'b10;
      chk("bp.full_ready", in4_ready, 0);
      tick();
      chk("bp.still_full", in4_ready, 0);
      chk("bp.head_a", out4_state, FIPS_OUT);
      out4_ready = 1'b1;
      tick();
      chk("bp.ready_back", in4_ready, 1);
      chk("bp.head_b", out4_state, FIPS_IN);
      tick();
      in4_valid = 1'b0;
      chk("bp.head_c", out4_state, 128'h0123456789abcdef_fedcba9876543210);
      chk("bp.mode_c", out4_mode, 2'b10);
      tick();
      chk("bp.drained", out4_valid, 0);

      // Streaming: one transaction per cycle.
      out4_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         st = {$urandom, $urandom, $urandom, $urandom};
         md = 2'(i % 4);
         in4_valid = 1'b1; in4_state = st; in4_mode = md;
         chk("stream.in_ready", in4_ready, 1);
         tick();
         chk("stream.valid", out4_valid, 1);
         chk("stream.state", out4_state, ref4(st, md));
         chk("stream.err", out4_err, (md == 2'b11));
      end
      in4_valid = 1'b0;
      tick();
      chk("stream.drained", out4_valid, 0);

      // Reset with two entries buffered.
      out4_ready = 1'b0;
      in4_valid = 1'b1; in4_state = FIPS_IN; in4_mode = 2'b00;
      tick();
      in4_state = FIPS_OUT; in4_mode = 2'b01;
      tick();
      in4_valid = 1'b0;
      chk("midrst.full", in4_ready, 0);
      chk("midrst.valid_before", out4_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("midrst.valid_now", out4_valid, 0);
      chk("midrst.ready_now", in4_ready, 0);
      chk("midrst.state_now", out4_state, 0);
      tick();
      #2 rst = 1'b0;
      out4_ready = 1'b1;
      tick();
      chk("midrst.ready_first_edge", in4_ready, 1);
      chk("midrst.no_stale0", out4_valid, 0);
      tick();
      chk("midrst.no_stale1", out4_valid, 0);
      xfer4("post_rst", 128'hcafef00d_deadbeef_01234567_89abcdef, 2'b10,
            128'hcafef00d_deadbeef_01234567_89abcdef);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
